// File: rtl/axi_r_arbiter.sv
// Round-robin, burst-locked merge of N_SRC AXI R channels onto one downstream R channel.
// Purely combinational forward path; only the arbitration state is registered.
//
// state  | meaning
// IDLE   | no burst in progress; the next valid source from rr_ptr is forwarded
// LOCKED | a burst (or a stalled beat) owns the output; only lock_idx is forwarded
module axi_r_arbiter #(
  parameter int N_SRC      = 4,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 6,
  parameter int IDX_WIDTH  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_SRC-1:0]            slave_valid_i,
  input  logic [N_SRC*DATA_WIDTH-1:0] slave_data_i,
  input  logic [N_SRC*2-1:0]          slave_resp_i,
  input  logic [N_SRC*USER_WIDTH-1:0] slave_user_i,
  input  logic [N_SRC*ID_WIDTH-1:0]   slave_id_i,
  input  logic [N_SRC-1:0]            slave_last_i,
  output logic [N_SRC-1:0]            slave_ready_o,
  output logic                        master_valid_o,
  output logic [DATA_WIDTH-1:0]       master_data_o,
  output logic [1:0]                  master_resp_o,
  output logic [USER_WIDTH-1:0]       master_user_o,
  output logic [ID_WIDTH-1:0]         master_id_o,
  output logic                        master_last_o,
  input  logic                        master_ready_i,
  output logic [IDX_WIDTH-1:0]        grant_idx_o,
  output logic                        locked_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_WIDTH-1:0] sel;
  logic [IDX_WIDTH-1:0] cand;
  logic                 found;
  logic                 hs;

  // Wraps modulo N_SRC, which differs from 2^IDX_WIDTH for non-power-of-two N_SRC.
  function automatic logic [IDX_WIDTH-1:0] inc_idx(input logic [IDX_WIDTH-1:0] v);
    if (int'(v) >= N_SRC - 1) return '0;
    return IDX_WIDTH'(int'(v) + 1);
  endfunction

  always_comb begin
    sel   = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    if (state_q == LOCKED) begin
      sel = lock_idx_q;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        cand = IDX_WIDTH'((int'(rr_ptr_q) + i) % N_SRC);
        if (!found && slave_valid_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    master_valid_o = 1'b0;
    master_data_o  = '0;
    master_resp_o  = '0;
    master_user_o  = '0;
    master_id_o    = '0;
    master_last_o  = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (sel == IDX_WIDTH'(k) && slave_valid_i[k]) begin
        master_valid_o = 1'b1;
        master_data_o  = slave_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        master_resp_o  = slave_resp_i[k*2 +: 2];
        master_user_o  = slave_user_i[k*USER_WIDTH +: USER_WIDTH];
        master_id_o    = slave_id_i[k*ID_WIDTH +: ID_WIDTH];
        master_last_o  = slave_last_i[k];
      end
    end
  end

  always_comb begin
    slave_ready_o = '0;
    for (int k = 0; k < N_SRC; k++) begin
      slave_ready_o[k] = master_ready_i & master_valid_o & (sel == IDX_WIDTH'(k));
    end
  end

  assign hs          = master_valid_o & master_ready_i;
  assign grant_idx_o = sel;
  assign locked_o    = (state_q == LOCKED);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (master_valid_o) begin
          if (hs && master_last_o) begin
            rr_ptr_d = inc_idx(sel);
          end else begin
            state_d    = LOCKED;
            lock_idx_d = sel;
          end
        end
      end
      LOCKED: begin
        if (hs && master_last_o) begin
          state_d  = IDLE;
          rr_ptr_d = inc_idx(lock_idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: doc/axi_r_arbiter.md
Name: axi_r_arbiter

Overview:
- Merges the AXI read-data (R) channels of N_SRC upstream sources onto one downstream R channel.
- Sits in front of an R-channel buffer in the interconnect response path.
- Arbitration is round-robin and burst-locked: once a source wins, its whole burst, up to and including the beat with last=1, goes through without interleaving.
- Presented beats stay stable while the downstream side stalls, as AXI requires.

Parameters:
- N_SRC, 4, number of upstream R sources (≥1).
- ID_WIDTH, 4, R ID width.
- DATA_WIDTH, 64, R data width.
- USER_WIDTH, 6, R user width.
- IDX_WIDTH, (N_SRC>1 ? $clog2(N_SRC) : 1), grant index width (derived, do not override).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- slave_valid_i  in  N_SRC  per-source R valid.
- slave_data_i  in  N_SRC*DATA_WIDTH  per-source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- slave_resp_i  in  N_SRC*2  per-source resp, same packing.
- slave_user_i  in  N_SRC*USER_WIDTH  per-source user, same packing.
- slave_id_i  in  N_SRC*ID_WIDTH  per-source ID, same packing.
- slave_last_i  in  N_SRC  per-source last.
- slave_ready_o  out  N_SRC  per-source ready.
- master_valid_o  out  1  merged R valid.
- master_data_o  out  DATA_WIDTH  merged data.
- master_resp_o  out  2  merged resp.
- master_user_o  out  USER_WIDTH  merged user.
- master_id_o  out  ID_WIDTH  merged ID.
- master_last_o  out  1  merged last.
- master_ready_i  in  1  downstream ready.
- grant_idx_o  out  IDX_WIDTH  index of the currently forwarded source.
- locked_o  out  1  1 while in state LOCKED.

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low on rst_ni.
- Reset values: state=IDLE, rr_ptr=0, lock_idx=0.
  - Outputs during and after reset follow the IDLE combinational rules with the current inputs.
  - With no valid inputs: master_valid_o=0 and locked_o=0.
- Latency: zero-cycle combinational forward path; no data storage.
- Selection index sel:
  - In IDLE, sel is the first k with slave_valid_i[k]=1, searching (rr_ptr, rr_ptr+1, ... ) mod N_SRC. Wrap is modulo N_SRC, not 2^IDX_WIDTH.
  - In LOCKED, sel=lock_idx.
- Output mux:
  - master_valid_o = slave_valid_i[sel] (IDLE: OR of all valids).
  - master_data/resp/user/id/last = source sel's fields when master_valid_o=1, else all zero.
  - grant_idx_o = sel; when IDLE and nothing is valid it equals rr_ptr.
- Ready routing: slave_ready_o[k] = master_ready_i & (k==sel) & master_valid_o. Every non-selected source sees ready=0.
- Handshake: hs = master_valid_o & master_ready_i.
- State transitions:
  - IDLE → LOCKED when master_valid_o & !(hs & master_last_o). This covers a stalled beat and a burst continuing past its first beat. lock_idx<=sel.
  - IDLE → IDLE when hs & master_last_o (single-beat burst). rr_ptr<=(sel+1) mod N_SRC.
  - IDLE → IDLE when nothing is valid; no register changes.
  - LOCKED → IDLE when hs & master_last_o. rr_ptr<=(lock_idx+1) mod N_SRC.
  - LOCKED → LOCKED otherwise.
- While LOCKED:
  - Valids from other sources are ignored.
  - If the locked source drops valid mid-burst, master_valid_o=0 and the lock holds. This is legal between beats.
- Stability: a stalled beat (valid=1, ready=0) stays on the same source until accepted, even if a higher-priority source becomes valid.
- rr_ptr changes only on a last-beat handshake. Non-last handshakes do not move it.
- N_SRC=1: sel is always 0; the FSM still runs; locked_o is reported normally.
- Reset asserted mid-burst returns to IDLE with rr_ptr=0 immediately. Upstream sources are reset by the same rst_ni.

Test Plan (N_SRC=4, DATA_WIDTH=64):
- Reset, all valids 0 → master_valid_o=0, locked_o=0, grant_idx_o=0, slave_ready_o=4'b0000.
- Sources 1 and 3 valid with single-beat bursts (last=1), master_ready_i=1 constant → accepted in order src1 then src3; grant_idx_o 1 then 3; rr_ptr=0 after the second beat.
- Source 0 sends a 4-beat burst (data 0xA0..0xA3) while source 2 is valid from cycle 1 → output is A0,A1,A2,A3 back to back, then source 2's beat; slave_ready_o[2]=0 throughout the burst.
- Source 2 valid with master_ready_i=0 for 3 cycles; source 1 becomes valid in cycle 1 → grant_idx_o stays 2, master_data_o stable, locked_o=1; source 2 is accepted when ready=1, then source 1.
- Source 3 burst of 3 beats with valid deasserted for 2 cycles between beats 1 and 2, source 0 valid meanwhile → master_valid_o=0 in the gap, lock_idx=3 held, source 0 granted only after the last beat; rr_ptr wraps 3→0.
- rst_ni asserted during beat 2 of a source 1 burst → locked_o=0 asynchronously, rr_ptr=0; after release with sources 0 and 1 valid, source 0 is granted first.
